// File: rtl/frv_trng_feeder.sv
// TRNG entropy feeder: buffers one raw TRNG word and shifts it LSB-first into the PRNG extra tap.
// Define FRV_TRNG_HEALTH_EN to add a repetition-count health test that blocks a stuck source.
module frv_trng_feeder #(
    parameter int TRNG_W    = 16,
    parameter int RCT_LIMIT = 4
) (
    input  logic                            g_clk,
    input  logic                            g_resetn,
    input  logic                            trng_valid,
    input  logic [TRNG_W-1:0]               trng_data,
    output logic                            trng_ready,
    input  logic                            core_update,
    output logic                            lfsr_update,
    output logic                            lfsr_extra_tap,
    output logic [$clog2(TRNG_W+1)-1:0]     ent_cnt,
    output logic                            health_fail,
    input  logic                            health_clear
);

    localparam int CNT_W = $clog2(TRNG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TRNG_W);

    logic [TRNG_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic shifting;
    logic accept;
    logic reject;
    logic fail_state;

    assign shifting   = (cnt_q != '0);
    assign trng_ready = (cnt_q == '0) && !fail_state;
    assign accept     = trng_valid && trng_ready;

`ifdef FRV_TRNG_HEALTH_EN
    logic [TRNG_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [7:0]        rep_q, rep_d;
    logic              fail_q, fail_d;
    logic [7:0]        rep_new;
    logic              hist_vld;

    // A clear in the same cycle as an accept makes this word the first of a new run.
    always_comb begin
        hist_vld   = prev_vld_q && !health_clear;
        rep_new    = (!hist_vld || (trng_data != prev_q)) ? 8'd1 : rep_q + 8'd1;
        reject     = accept && (rep_new == 8'(RCT_LIMIT));
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        rep_d      = rep_q;
        fail_d     = fail_q;
        if (health_clear) begin
            fail_d     = 1'b0;
            rep_d      = 8'd0;
            prev_vld_d = 1'b0;
        end
        if (accept) begin
            prev_d     = trng_data;
            prev_vld_d = 1'b1;
            if (reject) begin
                fail_d = 1'b1;
            end else begin
                rep_d = rep_new;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            rep_q      <= 8'd0;
            fail_q     <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            rep_q      <= rep_d;
            fail_q     <= fail_d;
        end
    end

    assign fail_state = fail_q;
`else
    logic       unused_health_clear;
    logic [7:0] unused_rct_limit;

    assign unused_health_clear = health_clear;
    assign unused_rct_limit    = 8'(RCT_LIMIT);
    assign reject              = 1'b0;
    assign fail_state          = 1'b0;
`endif

    // Accept and shift are mutually exclusive since ready requires an empty buffer.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (shifting) begin
            buf_d = buf_q >> 1;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (accept && !reject) begin
            buf_d = trng_data;
            cnt_d = CNT_FULL;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign lfsr_update    = core_update || shifting;
    assign lfsr_extra_tap = shifting && buf_q[0];
    assign ent_cnt        = cnt_q;
    assign health_fail    = fail_state;

endmodule

// File: tb/tb_frv_trng_feeder.sv
// Directed self-checking bench for frv_trng_feeder (TRNG_W=16, RCT_LIMIT=4).
`timescale 1ns/1ps
module tb_frv_trng_feeder;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        trng_valid = 1'b0;
    logic [15:0] trng_data = 16'h0000;
    logic        trng_ready;
    logic        core_update = 1'b0;
    logic        lfsr_update;
    logic        lfsr_extra_tap;
    logic [4:0]  ent_cnt;
    logic        health_fail;
    logic        health_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    frv_trng_feeder #(.TRNG_W(16), .RCT_LIMIT(4)) dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
        .trng_valid     (trng_valid),
        .trng_data      (trng_data),
        .trng_ready     (trng_ready),
        .core_update    (core_update),
        .lfsr_update    (lfsr_update),
        .lfsr_extra_tap (lfsr_extra_tap),
        .ent_cnt        (ent_cnt),
        .health_fail    (health_fail),
        .health_clear   (health_clear)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_reached errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Moves to 1 ns after the next rising edge; caller drives inputs, waits #1, then samples.
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        repeat (3) tick();
        g_resetn = 1'b1;
        #1;
        checks++; if (trng_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", trng_ready); end
        checks++; if (ent_cnt !== 5'd0) begin errors++; $display("FAIL reset_ent_cnt got=%0d want=0", ent_cnt); end
        checks++; if (lfsr_extra_tap !== 1'b0) begin errors++; $display("FAIL reset_tap got=%0b want=0", lfsr_extra_tap); end
        checks++; if (lfsr_update !== 1'b0) begin errors++; $display("FAIL reset_update got=%0b want=0", lfsr_update); end
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health got=%0b want=0", health_fail); end
        $display("test_reset done");
    endtask

    task automatic test_idle_update();
        logic exp_upd;
        for (int c = 0; c < 8; c++) begin
            tick();
            core_update = (c == 3) || (c == 5);
            exp_upd = (c == 3) || (c == 5);
            #1;
            checks++; if (lfsr_update !== exp_upd) begin errors++; $display("FAIL idle_update c=%0d got=%0b want=%0b", c, lfsr_update, exp_upd); end
            checks++; if (lfsr_extra_tap !== 1'b0) begin errors++; $display("FAIL idle_tap c=%0d got=%0b want=0", c, lfsr_extra_tap); end
            checks++; if (trng_ready !== 1'b1 || ent_cnt !== 5'd0) begin errors++; $display("FAIL idle_ready c=%0d ready=%0b cnt=%0d want 1/0", c, trng_ready, ent_cnt); end
        end
        tick();
        core_update = 1'b0;
        $display("test_idle_update done");
    endtask

    task automatic test_serialise_a5c3();
        int exp_bits [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
        trng_valid = 1'b1;
        trng_data  = 16'hA5C3;
        #1;
        checks++; if (trng_ready !== 1'b1) begin errors++; $display("FAIL a5c3_ready_before got=%0b want=1", trng_ready); end
        for (int i = 0; i < 16; i++) begin
            tick();
            trng_valid = 1'b0;
            #1;
            checks++; if (lfsr_extra_tap !== exp_bits[i][0]) begin errors++; $display("FAIL a5c3_tap i=%0d got=%0b want=%0d", i, lfsr_extra_tap, exp_bits[i]); end
            checks++; if (ent_cnt !== 5'(16 - i)) begin errors++; $display("FAIL a5c3_cnt i=%0d got=%0d want=%0d", i, ent_cnt, 16 - i); end
            checks++; if (lfsr_update !== 1'b1 || trng_ready !== 1'b0) begin errors++; $display("FAIL a5c3_upd_ready i=%0d upd=%0b ready=%0b want 1/0", i, lfsr_update, trng_ready); end
        end
        tick();
        #1;
        checks++; if (trng_ready !== 1'b1 || ent_cnt !== 5'd0) begin errors++; $display("FAIL a5c3_done ready=%0b cnt=%0d want 1/0", trng_ready, ent_cnt); end
        checks++; if (lfsr_update !== 1'b0 || lfsr_extra_tap !== 1'b0) begin errors++; $display("FAIL a5c3_idle upd=%0b tap=%0b want 0/0", lfsr_update, lfsr_extra_tap); end
        $display("test_serialise_a5c3 done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] acc_word;
        int ph;
        acc_word = 16'h0000;
        for (int c = 0; c < 52; c++) begin
            tick();
            trng_valid = 1'b1;
            trng_data  = 16'h5A00 ^ 16'(c * 16'h0B3D);
            #1;
            ph = c % 17;
            checks++; if (trng_ready !== (ph == 0)) begin errors++; $display("FAIL b2b_ready c=%0d got=%0b want=%0b", c, trng_ready, ph == 0); end
            if (ph == 0) begin
                acc_word = trng_data;
            end else begin
                checks++; if (lfsr_extra_tap !== acc_word[ph-1]) begin errors++; $display("FAIL b2b_tap c=%0d got=%0b want=%0b", c, lfsr_extra_tap, acc_word[ph-1]); end
                checks++; if (ent_cnt !== 5'(17 - ph)) begin errors++; $display("FAIL b2b_cnt c=%0d got=%0d want=%0d", c, ent_cnt, 17 - ph); end
            end
        end
        tick();
        trng_valid = 1'b0;
        // Last word accepted at c=51 still shifts; let it drain.
        repeat (17) tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_word();
        trng_valid = 1'b1;
        trng_data  = 16'hFFFF;
        for (int c = 1; c <= 5; c++) begin
            tick();
            trng_valid = 1'b0;
            if (c == 5) g_resetn = 1'b0;
            #1;
            checks++; if (lfsr_extra_tap !== 1'b1) begin errors++; $display("FAIL midrst_tap c=%0d got=%0b want=1", c, lfsr_extra_tap); end
        end
        tick();
        g_resetn = 1'b1;
        #1;
        checks++; if (ent_cnt !== 5'd0) begin errors++; $display("FAIL midrst_cnt got=%0d want=0", ent_cnt); end
        checks++; if (lfsr_extra_tap !== 1'b0) begin errors++; $display("FAIL midrst_tap_after got=%0b want=0", lfsr_extra_tap); end
        checks++; if (trng_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%0b want=1", trng_ready); end
        $display("test_reset_mid_word done");
    endtask

    // Offers w once ready; then either checks full serialisation or a health rejection.
    task automatic send_word(input logic [15:0] w, input bit expect_load, input int idx);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            #1;
            if (trng_ready === 1'b1) got = 1'b1;
            n++;
        end
        checks++; if (!got) begin errors++; $display("FAIL send_ready_timeout idx=%0d ready=%0b want=1", idx, trng_ready); end
        trng_valid = 1'b1;
        trng_data  = w;
        tick();
        trng_valid = 1'b0;
        #1;
        if (expect_load) begin
            for (int i = 0; i < 16; i++) begin
                if (i > 0) begin tick(); #1; end
                checks++; if (lfsr_extra_tap !== w[i] || ent_cnt !== 5'(16 - i)) begin errors++; $display("FAIL send_shift idx=%0d i=%0d tap=%0b cnt=%0d want %0b/%0d", idx, i, lfsr_extra_tap, ent_cnt, w[i], 16 - i); end
            end
            checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL send_health idx=%0d got=%0b want=0", idx, health_fail); end
        end else begin
            checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL reject_health idx=%0d got=%0b want=1", idx, health_fail); end
            checks++; if (ent_cnt !== 5'd0 || trng_ready !== 1'b0) begin errors++; $display("FAIL reject_state idx=%0d cnt=%0d ready=%0b want 0/0", idx, ent_cnt, trng_ready); end
        end
        $display("send_word idx=%0d data=%04h load=%0b", idx, w, expect_load);
    endtask

    task automatic pulse_clear();
        tick();
        health_clear = 1'b1;
        tick();
        health_clear = 1'b0;
        #1;
    endtask

`ifdef FRV_TRNG_HEALTH_EN
    task automatic test_health_rct();
        for (int k = 0; k < 3; k++) send_word(16'h1234, 1'b1, k);
        send_word(16'h1234, 1'b0, 3);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            checks++; if (trng_ready !== 1'b0 || health_fail !== 1'b1) begin errors++; $display("FAIL rct_blocked c=%0d ready=%0b fail=%0b want 0/1", c, trng_ready, health_fail); end
        end
        pulse_clear();
        checks++; if (trng_ready !== 1'b1 || health_fail !== 1'b0) begin errors++; $display("FAIL rct_clear ready=%0b fail=%0b want 1/0", trng_ready, health_fail); end
        for (int k = 4; k < 7; k++) send_word(16'h1234, 1'b1, k);
        send_word(16'h1234, 1'b0, 7);
        pulse_clear();
        $display("test_health_rct done");
    endtask

    task automatic test_health_alternating();
        for (int k = 0; k < 10; k++) send_word((k % 2) ? 16'h1235 : 16'h1234, 1'b1, 10 + k);
        $display("test_health_alternating done");
    endtask
`else
    task automatic test_no_health();
        for (int k = 0; k < 4; k++) send_word(16'h1234, 1'b1, k);
        pulse_clear();
        checks++; if (health_fail !== 1'b0 || trng_ready !== 1'b1) begin errors++; $display("FAIL nohealth_after fail=%0b ready=%0b want 0/1", health_fail, trng_ready); end
        $display("test_no_health done");
    endtask
`endif

    initial begin
        test_reset();
        test_idle_update();
        test_serialise_a5c3();
        test_back_to_back();
        test_reset_mid_word();
`ifdef FRV_TRNG_HEALTH_EN
        test_health_rct();
        test_health_alternating();
`else
        test_no_health();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
